// File: rtl/plic_icb_arb_pkg.sv
// Shared types and defaults for the PLIC ICB two-master arbiter.
package plic_icb_arb_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_BUS      = 32;
    localparam int ARB_TMO_CYC  = 64;
    localparam int ARB_TMO_W    = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_LRSP = 2'd2,
        ARB_TERR = 2'd3
    } arb_state_e;

    // Timeout limit as seen by the 8-bit wait counter.
    function automatic logic [ARB_TMO_W-1:0] tmo_limit(input int cyc);
        return ARB_TMO_W'(cyc);
    endfunction

endpackage

// File: rtl/plic_icb_arb_rr_arb2.sv
// Two-request round-robin grant; last_gnt moves only on an accepted request.
module plic_icb_arb_rr_arb2
    import plic_icb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        gnt = ~last_gnt_q;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = ~last_gnt_q;
        endcase
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (accept) begin
            last_gnt_d = gnt;
        end
    end

    // Reset to 1 so master 0 wins the first contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/plic_icb_arb.sv
// Shares the PLIC ICB port between the core LSU (m0) and debug/DMA (m1),
// one transaction in flight, with local write and timeout responses.
module plic_icb_arb
    import plic_icb_arb_pkg::*;
#(
    parameter int AW      = MEM_ADDR_BUS,
    parameter int DW      = MEM_BUS,
    parameter int WR_RSP  = 0,
    parameter int TMO_CYC = ARB_TMO_CYC
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic            m0_icb_cmd_read,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic            m0_icb_rsp_err,
    output logic [DW-1:0]   m0_icb_rsp_rdata,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic            m1_icb_cmd_read,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic            m1_icb_rsp_err,
    output logic [DW-1:0]   m1_icb_rsp_rdata,

    output logic            slv_icb_cmd_valid,
    input  logic            slv_icb_cmd_ready,
    output logic [AW-1:0]   slv_icb_cmd_addr,
    output logic            slv_icb_cmd_read,
    output logic [DW-1:0]   slv_icb_cmd_wdata,
    output logic [DW/8-1:0] slv_icb_cmd_wmask,
    input  logic            slv_icb_rsp_valid,
    output logic            slv_icb_rsp_ready,
    input  logic            slv_icb_rsp_err,
    input  logic [DW-1:0]   slv_icb_rsp_rdata
);

    localparam logic [ARB_TMO_W-1:0] TMO_LIM = tmo_limit(TMO_CYC);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic [ARB_TMO_W-1:0] cnt_q, cnt_d;

    logic          gnt;
    logic          accept;
    logic          own_rsp_ready;
    logic          rsp_vld;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          cmd_vld;
    logic          cmd_rdy0;
    logic          cmd_rdy1;
    logic          srsp_rdy;

    plic_icb_arb_rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign slv_icb_cmd_addr  = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign slv_icb_cmd_read  = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign slv_icb_cmd_wdata = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign slv_icb_cmd_wmask = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign own_rsp_ready = owner_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        cmd_vld   = 1'b0;
        cmd_rdy0  = 1'b0;
        cmd_rdy1  = 1'b0;
        srsp_rdy  = 1'b0;
        rsp_vld   = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        accept    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                cmd_vld  = m0_icb_cmd_valid | m1_icb_cmd_valid;
                cmd_rdy0 = ~gnt & slv_icb_cmd_ready;
                cmd_rdy1 = gnt & slv_icb_cmd_ready;
                srsp_rdy = 1'b1;
                if (cmd_vld && slv_icb_cmd_ready && !rst) begin
                    accept  = 1'b1;
                    owner_d = gnt;
                    cnt_d   = '0;
                    if (slv_icb_cmd_read || WR_RSP != 0) begin
                        state_d = ARB_WAIT;
                    end else begin
                        state_d = ARB_LRSP;
                    end
                end
            end
            ARB_WAIT: begin
                rsp_vld   = slv_icb_rsp_valid;
                rsp_err   = slv_icb_rsp_err;
                rsp_rdata = slv_icb_rsp_rdata;
                srsp_rdy  = own_rsp_ready;
                if (slv_icb_rsp_valid && own_rsp_ready) begin
                    state_d = ARB_IDLE;
                end else if (!slv_icb_rsp_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (TMO_CYC != 0 && cnt_d == TMO_LIM) begin
                        state_d = ARB_TERR;
                    end
                end
            end
            ARB_LRSP: begin
                rsp_vld  = 1'b1;
                srsp_rdy = 1'b1;
                if (own_rsp_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_TERR: begin
                rsp_vld  = 1'b1;
                rsp_err  = 1'b1;
                srsp_rdy = 1'b1;
                if (own_rsp_ready) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase

        // Handshake outputs are forced low for as long as reset is held.
        if (rst) begin
            cmd_vld  = 1'b0;
            cmd_rdy0 = 1'b0;
            cmd_rdy1 = 1'b0;
            srsp_rdy = 1'b0;
            rsp_vld  = 1'b0;
        end
    end

    assign slv_icb_cmd_valid = cmd_vld;
    assign m0_icb_cmd_ready  = cmd_rdy0;
    assign m1_icb_cmd_ready  = cmd_rdy1;
    assign slv_icb_rsp_ready = srsp_rdy;

    assign m0_icb_rsp_valid = rsp_vld & ~owner_q;
    assign m0_icb_rsp_err   = rsp_err & ~owner_q;
    assign m0_icb_rsp_rdata = owner_q ? '0 : rsp_rdata;
    assign m1_icb_rsp_valid = rsp_vld & owner_q;
    assign m1_icb_rsp_err   = rsp_err & owner_q;
    assign m1_icb_rsp_rdata = owner_q ? rsp_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/plic_icb_arb.md
Name: plic_icb_arb

Overview:
- Two-master to one-slave ICB arbiter that shares the PLIC register port between master 0 (core LSU) and master 1 (debug/DMA).
- Round-robin grant; one outstanding transaction at a time.
- Routes each response back to the master that issued the command.
- Synthesizes write responses for slaves that answer reads only (as the PLIC does), and returns an error response when the slave does not answer within a timeout.

Parameters:
- AW, 32, address width (matches MemAddrBus).
- DW, 32, data width (matches MemBus); the wmask width is DW/8.
- WR_RSP, 0, 0 = the slave returns no write response, so the arbiter generates it; 1 = the slave responds to every command.
- TMO_CYC, 64, number of cycles to wait for a slave response before returning an error; 0 disables the timeout; counter is 8 bits.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- mN_icb_cmd_valid (N=0,1)  in  1  master command request.
- mN_icb_cmd_ready  out  1  command accepted.
- mN_icb_cmd_addr  in  AW  command address.
- mN_icb_cmd_read  in  1  1 = read, 0 = write.
- mN_icb_cmd_wdata  in  DW  write data.
- mN_icb_cmd_wmask  in  DW/8  byte strobes.
- mN_icb_rsp_valid  out  1  response to master N.
- mN_icb_rsp_ready  in  1  master N accepts the response.
- mN_icb_rsp_err  out  1  response error.
- mN_icb_rsp_rdata  out  DW  read data.
- slv_icb_cmd_valid, slv_icb_cmd_read  out  1  command to the PLIC.
- slv_icb_cmd_addr  out  AW; slv_icb_cmd_wdata  out  DW; slv_icb_cmd_wmask  out  DW/8.
- slv_icb_cmd_ready, slv_icb_rsp_valid, slv_icb_rsp_err  in  1.
- slv_icb_rsp_rdata  in  DW.
- slv_icb_rsp_ready  out  1.

Behaviour:
- States: IDLE, WAIT (slave response outstanding), LRSP (local write response), TERR (timeout error response).
- Reset (async):
  - state=IDLE, owner=0, last_gnt=1 so m0 wins first, timeout counter=0.
  - While rst is high, every *_valid and *_ready output is 0.
- IDLE grant:
  - If only one master is valid, grant that master.
  - If both are valid, grant the one that is not last_gnt.
  - Grant is combinational and re-evaluated each cycle; last_gnt updates only on a slave cmd handshake.
- IDLE command path:
  - slv_icb_cmd_valid = m0_icb_cmd_valid | m1_icb_cmd_valid.
  - addr/read/wdata/wmask are muxed from the granted master; no added latency.
  - Only the granted master sees mN_icb_cmd_ready = slv_icb_cmd_ready; the other master sees 0.
- Outside IDLE: slv_icb_cmd_valid=0 and both mN_icb_cmd_ready=0.
- On slave cmd handshake: latch owner.
  - Read, or WR_RSP=1 -> WAIT (counter cleared).
  - Write with WR_RSP=0 -> LRSP.
- WAIT:
  - m[owner]_icb_rsp_valid/err/rdata = slv_icb_rsp_*; slv_icb_rsp_ready = m[owner]_icb_rsp_ready.
  - On the response handshake -> IDLE.
  - The counter increments on each WAIT cycle with slv_icb_rsp_valid=0.
  - If TMO_CYC≠0 and the count reaches TMO_CYC -> TERR.
- LRSP: m[owner]_icb_rsp_valid=1, err=0, rdata=0; stays until m[owner]_icb_rsp_ready, then -> IDLE.
- TERR: m[owner]_icb_rsp_valid=1, err=1, rdata=0; stays until m[owner]_icb_rsp_ready, then -> IDLE.
- slv_icb_rsp_ready=1 in IDLE, LRSP and TERR. Stray or late slave responses are sunk and discarded, never forwarded.
- The non-owner master's rsp_valid is always 0.
- Throughput with the PLIC (read response 1 cycle after cmd):
  - cmd at T, response at T+1; with master ready at T+1 the next cmd is at T+2.
  - Write with WR_RSP=0: cmd at T, local response at T+1.
- Slave cmd backpressure in IDLE: no master handshake and last_gnt is unchanged.
- Reset mid-transaction: the pending response is dropped and no valid is emitted; after release the block starts in IDLE with m0 priority.

Decomposition:
- Add to defines.v:
  - the 2-bit state encodings `ArbIdle / `ArbWait / `ArbLrsp / `ArbTerr;
  - the default `ArbTmoCyc.
- Reuse `MemAddrBus / `MemBus.
- One natural sub-module: rr_arb2. It contains the 2-request round-robin grant plus the last_gnt register, updated on an accept pulse.

Test Plan:
- Read routing: after reset, m0 reads 0x00002000 and the slave returns 0x0000_00A5 next cycle -> m0_icb_rsp_valid=1 with rdata=0x000000A5 at T+1; m1_icb_rsp_valid stays 0.
- Round-robin: m0 and m1 each hold 4 reads continuously -> slave grant order is 0,1,0,1,0,1,0,1, one cmd every 2 cycles.
- Local write response: m1 writes 0x00200000 with wdata=2 (WR_RSP=0) and holds m1_icb_rsp_ready=0 for 3 cycles -> rsp_valid=1, err=0, rdata=0 held 3 cycles; m0 cmd_ready=0 throughout.
- Timeout: TMO_CYC=16 and the slave never responds to an m0 read -> m0 rsp_err=1 after 16 WAIT cycles; a late slave rsp in IDLE is consumed with no master rsp_valid.
- Slave backpressure: slv_icb_cmd_ready=0 for 5 cycles with both masters valid -> both cmd_ready=0 and m0 is granted on release.
- Reset in WAIT: assert rst mid-read -> all valid outputs drop immediately; after release, a new m1 read completes normally and m0 keeps first priority.
